// File: rtl/chk_pkg.sv
// Shared types and constants for the PC checkpoint checker.
// Optional feature FAIL_CONTINUE_EN is selected in pc_checkpoint_checker.
package chk_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      SETTLE,
      SCAN,
      REPORT,
      DONE
   } state_t;

   localparam int PC_LSB = 0;
   localparam int LO_LSB = 16;
   localparam int HI_LSB = 24;

   localparam logic [7:0] ERR_MAX = 8'hFF;

   typedef struct packed {
      logic [7:0]  hi;
      logic [7:0]  lo;
      logic [15:0] pc;
   } ckpt_t;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == ERR_MAX) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/shadow_dm.sv
// Snooped copy of the CPU data memory: one write port, one
// combinational read port, cleared by the asynchronous reset.
module shadow_dm
   import chk_pkg::*;
#(
   parameter int bit_size = 32,
   parameter int mem_size = 16,
   parameter int DEPTH    = 100,
   parameter int IDX_W    = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                we,
   input  logic [mem_size-1:0] waddr,
   input  logic [bit_size-1:0] wdata,
   input  logic [IDX_W-1:0]    raddr,
   output logic [bit_size-1:0] rdata
);

   localparam logic [mem_size-1:0] LIMIT = mem_size'(DEPTH);

   logic [bit_size-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
      end else if (we && (waddr < LIMIT)) begin
         mem[waddr[IDX_W-1:0]] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/pc_checkpoint_checker.sv
// In-system checker: scans shadow DM slices against a golden table at
// programmed PCs, with a watchdog. Define FAIL_CONTINUE_EN to keep going on mismatch.
module pc_checkpoint_checker
   import chk_pkg::*;
#(
   parameter int bit_size = 32,
   parameter int mem_size = 16,
   parameter int DEPTH    = 100,
   parameter int NUM_CKPT = 4,
   parameter int TIMEOUT  = 1000,
   localparam int IDX_W   = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [mem_size-1:0] IM_Address,
   input  logic                DM_enable,
   input  logic [mem_size-1:0] DM_Address,
   input  logic [bit_size-1:0] DM_Write_Data,
   input  logic                cfg_we,
   input  logic                cfg_sel,
   input  logic [7:0]          cfg_addr,
   input  logic [bit_size-1:0] cfg_wdata,
   input  logic                start,
   output logic                busy,
   output logic [IDX_W-1:0]    ckpt_idx,
   output logic                ckpt_pass,
   output logic                ckpt_fail,
   output logic [IDX_W-1:0]    err_index,
   output logic [bit_size-1:0] err_data,
   output logic [7:0]          err_count,
   output logic                done,
   output logic                pass,
   output logic                timeout
);

   localparam int KW = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [7:0] LAST_IDX = 8'(DEPTH - 1);

   state_t state, state_nx;

   logic [bit_size-1:0] golden [DEPTH];
   ckpt_t               ckpt_tab [NUM_CKPT];

   logic [KW-1:0]       k;
   logic [7:0]          i;
   logic [CW-1:0]       cnt;
   logic                bad;
   logic [bit_size-1:0] sh_rd;
   ckpt_t               cur;
   logic [7:0]          hi_c;
   logic idle_like, busy_w, wd_hit, empty, mism;
   logic last_word, last_ckpt, stop_scan, stop_run;

   shadow_dm #(
      .bit_size(bit_size),
      .mem_size(mem_size),
      .DEPTH   (DEPTH),
      .IDX_W   (IDX_W)
   ) u_shadow (
      .clk  (clk),
      .rst_n(rst),
      .we   (DM_enable),
      .waddr(DM_Address),
      .wdata(DM_Write_Data),
      .raddr(i[IDX_W-1:0]),
      .rdata(sh_rd)
   );

   assign idle_like = (state == IDLE) || (state == DONE);
   assign busy_w    = !idle_like;
   assign wd_hit    = busy_w && (cnt == CW'(TIMEOUT - 1));
   assign cur       = ckpt_tab[k];
   assign hi_c      = (cur.hi >= LAST_IDX) ? LAST_IDX : cur.hi;
   assign empty     = cur.lo > hi_c;
   assign mism      = (state == SCAN) && (sh_rd != golden[i[IDX_W-1:0]]);
   assign last_word = (i == hi_c);
   assign last_ckpt = (k == KW'(NUM_CKPT - 1));

`ifdef FAIL_CONTINUE_EN
   assign stop_scan = last_word;
   assign stop_run  = 1'b0;
`else
   assign stop_scan = last_word || mism;
   assign stop_run  = bad;
`endif

   // Tables are write-only from the config port and only while idle.
   always_ff @(posedge clk) begin
      if (cfg_we && idle_like) begin
         if (!cfg_sel) begin
            if ({1'b0, cfg_addr} < 9'(DEPTH))
               golden[cfg_addr[IDX_W-1:0]] <= cfg_wdata;
         end else if ({1'b0, cfg_addr} < 9'(NUM_CKPT)) begin
            ckpt_tab[cfg_addr[KW-1:0]] <= '{
               hi: cfg_wdata[HI_LSB +: 8],
               lo: cfg_wdata[LO_LSB +: 8],
               pc: cfg_wdata[PC_LSB +: 16]
            };
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE, DONE: if (start) state_nx = ARMED;
         ARMED:
            if (IM_Address == cur.pc[mem_size-1:0])
               state_nx = SETTLE;
         SETTLE: state_nx = empty ? REPORT : SCAN;
         SCAN:   if (stop_scan) state_nx = REPORT;
         REPORT:
            state_nx = (last_ckpt || stop_run) ? DONE : ARMED;
         default: state_nx = IDLE;
      endcase
      if (wd_hit) state_nx = DONE;
   end

   always_comb begin
      busy      = busy_w;
      done      = (state == DONE);
      ckpt_pass = (state == REPORT) && !bad && !wd_hit;
      ckpt_fail = (state == REPORT) && bad && !wd_hit;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k         <= '0;
         i         <= '0;
         cnt       <= '0;
         bad       <= 1'b0;
         timeout   <= 1'b0;
         err_index <= '0;
         err_data  <= '0;
         err_count <= '0;
      end else if (idle_like && start) begin
         k         <= '0;
         cnt       <= '0;
         bad       <= 1'b0;
         timeout   <= 1'b0;
         err_index <= '0;
         err_data  <= '0;
         err_count <= '0;
      end else if (busy_w) begin
         cnt <= cnt + 1'b1;
         if (wd_hit) begin
            timeout <= 1'b1;
         end else if (state == SETTLE) begin
            i   <= cur.lo;
            bad <= 1'b0;
         end else if (state == SCAN) begin
            i <= i + 8'd1;
            if (mism) begin
               bad       <= 1'b1;
               err_count <= sat_inc(err_count);
               if (err_count == '0) begin
                  err_index <= i[IDX_W-1:0];
                  err_data  <= sh_rd;
               end
            end
         end else if (state == REPORT && !last_ckpt) begin
            k <= k + 1'b1;
         end
      end
   end

   assign ckpt_idx = IDX_W'(k);
   assign pass     = done && !timeout && (err_count == '0);

endmodule
